psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/psum_pkg.sv | 21 ++
 rtl/psum_accumulator_if.sv | 23 ++
 rtl/psum_approx_add.sv | 25 ++
 rtl/psum_accumulator.sv | 107 ++++++++++
 tb/tb_psum_accumulator.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_pkg.sv
// Shared types and saturation-limit helpers for the partial-sum accumulator.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int MAX_ACC_WIDTH = 64;

    // Limits are returned right-aligned; the caller keeps the low `width` bits.
    function automatic logic [MAX_ACC_WIDTH-1:0] sat_pos(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_ACC_WIDTH-1:0] sat_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Valid/ready operand and result bus of the partial-sum accumulator.
interface psum_accumulator_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/psum_approx_add.sv
// Approximate adder: low IGNORE_BIT bits are ORed, the upper part adds exactly with
// a carry guessed from the top ignored bit. Result is one bit wider for overflow checks.
module psum_approx_add #(
    parameter int WIDTH      = 32,
    parameter int IGNORE_BIT = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);
    generate
        if (IGNORE_BIT == 0) begin : g_exact
            assign sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        end else begin : g_approx
            logic                      carry;
            logic [WIDTH-IGNORE_BIT:0] upper;

            assign carry = a[IGNORE_BIT-1] & b[IGNORE_BIT-1];
            assign upper = {a[WIDTH-1], a[WIDTH-1:IGNORE_BIT]}
                         + {b[WIDTH-1], b[WIDTH-1:IGNORE_BIT]}
                         + {{(WIDTH-IGNORE_BIT){1'b0}}, carry};
            assign sum   = {upper, a[IGNORE_BIT-1:0] | b[IGNORE_BIT-1:0]};
        end
    endgenerate
endmodule

// File: rtl/psum_accumulator.sv
// Sums DEPTH signed operands per result and holds the result until consumed.
// Define PSUM_ACC_SAT_EN for saturating accumulation with a sticky out_sat flag.
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int IGNORE_BIT = 0,
    parameter int DEPTH      = 8
) (
    input logic               clk,
    input logic               rst,
    psum_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t               state, state_next;
    logic [ACC_WIDTH-1:0] acc, acc_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 sat, sat_next;

    logic                 accept;
    logic [IN_WIDTH-1:0]  in_op;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] add_res;
    logic                 add_ovf;

    assign in_op  = bus.in_data;
    assign in_ext = ACC_WIDTH'($signed(in_op));

    psum_approx_add #(
        .WIDTH      (ACC_WIDTH),
        .IGNORE_BIT (IGNORE_BIT)
    ) u_add (
        .a   (acc),
        .b   (in_ext),
        .sum (sum_wide)
    );

`ifdef PSUM_ACC_SAT_EN
    localparam logic [MAX_ACC_WIDTH-1:0] SAT_POS_FULL = sat_pos(ACC_WIDTH);
    localparam logic [MAX_ACC_WIDTH-1:0] SAT_NEG_FULL = sat_neg(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0]     SAT_POS      = SAT_POS_FULL[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]     SAT_NEG      = SAT_NEG_FULL[ACC_WIDTH-1:0];

    // Overflow shows as disagreement between the guard bit and the result sign.
    assign add_ovf = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign add_res = !add_ovf           ? sum_wide[ACC_WIDTH-1:0] :
                     sum_wide[ACC_WIDTH] ? SAT_NEG : SAT_POS;
`else
    logic unused_guard;
    assign unused_guard = sum_wide[ACC_WIDTH];
    assign add_ovf      = 1'b0;
    assign add_res      = sum_wide[ACC_WIDTH-1:0];
`endif

    assign bus.in_ready  = !rst && (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = acc;
    assign bus.out_sat   = sat;
    assign accept        = bus.in_valid && bus.in_ready;

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sat_next   = sat;
        unique case (state)
            IDLE: if (accept) begin
                acc_next   = in_ext;
                cnt_next   = CNT_W'(1);
                sat_next   = 1'b0;
                state_next = (DEPTH == 1) ? HOLD : ACC;
            end
            ACC: if (accept) begin
                acc_next = add_res;
                cnt_next = cnt + 1'b1;
                sat_next = sat | add_ovf;
                if (cnt == CNT_W'(DEPTH - 1)) state_next = HOLD;
            end
            HOLD: if (bus.out_ready) begin
                acc_next   = '0;
                cnt_next   = '0;
                sat_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            sat   <= sat_next;
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator over four configurations; honours PSUM_ACC_SAT_EN.
module tb_psum_accumulator;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    psum_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32)) d4_if ();
    psum_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32)) ib_if ();
    psum_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(16)) w16_if ();
    psum_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32)) d1_if ();

    psum_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .IGNORE_BIT(0), .DEPTH(4))
        u_d4 (.clk(clk), .rst(rst), .bus(d4_if));
    psum_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .IGNORE_BIT(4), .DEPTH(2))
        u_ib (.clk(clk), .rst(rst), .bus(ib_if));
    psum_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16), .IGNORE_BIT(0), .DEPTH(2))
        u_w16 (.clk(clk), .rst(rst), .bus(w16_if));
    psum_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .IGNORE_BIT(0), .DEPTH(1))
        u_d1 (.clk(clk), .rst(rst), .bus(d1_if));

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic d4_push(input logic [15:0] v);
        d4_if.in_valid = 1'b1;
        d4_if.in_data  = v;
        @(negedge clk);
        d4_if.in_valid = 1'b0;
    endtask

    task automatic ib_push(input logic [15:0] v);
        ib_if.in_valid = 1'b1;
        ib_if.in_data  = v;
        @(negedge clk);
        ib_if.in_valid = 1'b0;
    endtask

    task automatic w16_push(input logic [15:0] v);
        w16_if.in_valid = 1'b1;
        w16_if.in_data  = v;
        @(negedge clk);
        w16_if.in_valid = 1'b0;
    endtask

    task automatic release_all();
        d4_if.out_ready  = 1'b1;
        ib_if.out_ready  = 1'b1;
        w16_if.out_ready = 1'b1;
        d1_if.out_ready  = 1'b1;
        @(negedge clk);
        d4_if.out_ready  = 1'b0;
        ib_if.out_ready  = 1'b0;
        w16_if.out_ready = 1'b0;
        d1_if.out_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (d4_if.out_valid !== 1'b0 || d4_if.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: out_valid=%b in_ready=%b want 0 0", d4_if.out_valid, d4_if.in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({d4_if.in_ready, d4_if.out_valid, d4_if.out_sat} !== 3'b100 || d4_if.out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_release: rdy/vld/sat=%b%b%b data=%h want 100 00000000",
                     d4_if.in_ready, d4_if.out_valid, d4_if.out_sat, d4_if.out_data);
        end
    endtask

    task automatic test_back_to_back_and_stall();
        d4_if.in_valid = 1'b1;
        d4_if.in_data  = 16'd1; @(negedge clk);
        d4_if.in_data  = 16'd2; @(negedge clk);
        d4_if.in_data  = 16'd3; @(negedge clk);
        vectors++;
        if (d4_if.out_valid !== 1'b0 || d4_if.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_before_last: out_valid=%b in_ready=%b want 0 1", d4_if.out_valid, d4_if.in_ready);
        end
        d4_if.in_data = 16'd4; @(negedge clk);
        // Keep offering a foreign operand while the result is stalled.
        d4_if.in_data = 16'd99;
        vectors++;
        if (d4_if.out_valid !== 1'b1 || d4_if.out_data !== 32'd10 || d4_if.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_result: vld=%b data=%0d rdy=%b want 1 10 0",
                     d4_if.out_valid, d4_if.out_data, d4_if.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (d4_if.out_valid !== 1'b1 || d4_if.out_data !== 32'd10 || d4_if.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_%0d: vld=%b data=%0d rdy=%b want 1 10 0",
                         i, d4_if.out_valid, d4_if.out_data, d4_if.in_ready);
            end
        end
        d4_if.in_valid = 1'b0;
        release_all();
        vectors++;
        if (d4_if.out_valid !== 1'b0 || d4_if.in_ready !== 1'b1 || d4_if.out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL stall_release: vld=%b rdy=%b data=%0d want 0 1 0",
                     d4_if.out_valid, d4_if.in_ready, d4_if.out_data);
        end
    endtask

    task automatic test_bubbles();
        d4_push(-16'sd5);
        @(negedge clk);
        d4_push(16'sd3);
        @(negedge clk);
        @(negedge clk);
        d4_push(-16'sd1);
        vectors++;
        if (d4_if.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_early_valid: out_valid=%b want 0", d4_if.out_valid);
        end
        @(negedge clk);
        d4_push(16'sd2);
        vectors++;
        if (d4_if.out_valid !== 1'b1 || d4_if.out_data !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL bubble_result: vld=%b data=%h want 1 ffffffff", d4_if.out_valid, d4_if.out_data);
        end
        release_all();
    endtask

    task automatic test_approx();
        logic [31:0] want [3] = '{32'h0000_000F, 32'h0000_0018, 32'h0000_000F};
        logic [15:0] ops  [6] = '{16'h000F, 16'h0001, 16'h0008, 16'h0008, 16'hFFFF, 16'h0010};
        for (int k = 0; k < 3; k++) begin
            ib_push(ops[2*k]);
            ib_push(ops[2*k+1]);
            vectors++;
            if (ib_if.out_valid !== 1'b1 || ib_if.out_data !== want[k]) begin
                miscompares++;
                $display("FAIL approx_%0d: vld=%b data=%h want 1 %h", k, ib_if.out_valid, ib_if.out_data, want[k]);
            end
            release_all();
        end
    endtask

    task automatic test_saturation();
        logic [15:0] ops [6] = '{16'h7FFF, 16'h0001, 16'h8000, 16'hFFFF, 16'h0001, 16'h0002};
`ifdef PSUM_ACC_SAT_EN
        logic [15:0] want [3] = '{16'h7FFF, 16'h8000, 16'h0003};
        logic        wsat [3] = '{1'b1, 1'b1, 1'b0};
`else
        logic [15:0] want [3] = '{16'h8000, 16'h7FFF, 16'h0003};
        logic        wsat [3] = '{1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 3; k++) begin
            w16_push(ops[2*k]);
            w16_push(ops[2*k+1]);
            vectors++;
            if (w16_if.out_valid !== 1'b1 || w16_if.out_data !== want[k] || w16_if.out_sat !== wsat[k]) begin
                miscompares++;
                $display("FAIL sat_%0d: vld=%b data=%h sat=%b want 1 %h %b",
                         k, w16_if.out_valid, w16_if.out_data, w16_if.out_sat, want[k], wsat[k]);
            end
            release_all();
        end
    endtask

    task automatic test_depth_one();
        d1_if.in_valid = 1'b1;
        d1_if.in_data  = 16'd7;
        @(negedge clk);
        d1_if.in_valid = 1'b0;
        vectors++;
        if (d1_if.out_valid !== 1'b1 || d1_if.out_data !== 32'd7 || d1_if.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL depth1: vld=%b data=%0d rdy=%b want 1 7 0", d1_if.out_valid, d1_if.out_data, d1_if.in_ready);
        end
        release_all();
    endtask

    task automatic test_reset_mid();
        d4_push(16'd5);
        d4_push(16'd6);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (d4_if.out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_async_clear: data=%0d want 0", d4_if.out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) d4_push(16'd1);
        vectors++;
        if (d4_if.out_valid !== 1'b1 || d4_if.out_data !== 32'd4) begin
            miscompares++;
            $display("FAIL rst_mid_result: vld=%b data=%0d want 1 4", d4_if.out_valid, d4_if.out_data);
        end
        // Reset while a result is waiting drops it without a consumer handshake.
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (d4_if.out_valid !== 1'b0 || d4_if.out_data !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_in_hold: vld=%b data=%0d want 0 0", d4_if.out_valid, d4_if.out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (d4_if.in_ready !== 1'b1 || d4_if.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hold_release: rdy=%b vld=%b want 1 0", d4_if.in_ready, d4_if.out_valid);
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        vectors     = 0;
        miscompares = 0;
        {d4_if.in_valid, d4_if.out_ready, d4_if.in_data}    = '0;
        {ib_if.in_valid, ib_if.out_ready, ib_if.in_data}    = '0;
        {w16_if.in_valid, w16_if.out_ready, w16_if.in_data} = '0;
        {d1_if.in_valid, d1_if.out_ready, d1_if.in_data}    = '0;
        @(negedge clk);
        test_reset();
        test_back_to_back_and_stall();
        test_bubbles();
        test_approx();
        test_saturation();
        test_depth_one();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
